uart_tx_sreg: RTL and testbench

Parallel-in, serial-out UART transmit shifter: the transmit-side counterpart of the UART receive shift register that feeds the RX FIFO. It accepts one byte from the TX FIFO/controller via a ready/load handshake. It emits an 8N1 frame on TXD: start bit, 8 data bits LSB first, one stop bit. Bit timing comes from an internal clocks-per-bit counter.

---
 rtl/uart_tx_sreg.sv | 134 +++++++++++++
 tb/tb_uart_tx_sreg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sreg.sv
// UART 8N1 transmit shifter: loads one word through a Ready/Load handshake and
// sends start bit, DATA_WIDTH data bits LSB first and one stop bit on TXD.
module uart_tx_sreg #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Load,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  Ready,
    output logic                  Done,
    output logic                  TXD
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_sreg: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [BAUD_W-1:0]       baud_r;
    logic [BIT_W-1:0]        bit_r;
    logic [DATA_WIDTH-1:0]   shreg_r;
    logic [DATA_WIDTH-1:0]   shifted_s;
    logic                    txd_r;
    logic                    done_r;
    logic                    txd_next_s;
    logic                    done_next_s;
    logic                    bit_end_s;
    logic                    accept_s;

    assign bit_end_s = (state_r != IDLE) && (baud_r == BAUD_LAST);
    assign accept_s  = (state_r == IDLE) && Load;
    assign shifted_s = shreg_r >> 1;
    assign TXD       = txd_r;
    assign Done      = done_r;

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; every non-IDLE state advances only at bit-end.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (Load) state_next_s = START;
                else      state_next_s = IDLE;
            end
            START: begin
                if (bit_end_s) state_next_s = DATA;
                else           state_next_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_r == BIT_LAST)) state_next_s = STOP;
                else                                  state_next_s = DATA;
            end
            STOP: begin
                if (bit_end_s) state_next_s = IDLE;
                else           state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: TXD is precomputed from the next state so the flop
    // shows the new bit level on the very cycle the state changes.
    always_comb begin
        Ready       = (state_r == IDLE);
        done_next_s = (state_r == STOP) && bit_end_s;
        txd_next_s  = 1'b1;
        case (state_next_s)
            IDLE:  txd_next_s = 1'b1;
            START: txd_next_s = 1'b0;
            DATA: begin
                if ((state_r == DATA) && bit_end_s) txd_next_s = shifted_s[0];
                else                                txd_next_s = shreg_r[0];
            end
            STOP:    txd_next_s = 1'b1;
            default: txd_next_s = 1'b1;
        endcase
    end

    // Datapath: baud/bit counters, shift register and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shreg_r <= {DATA_WIDTH{1'b0}};
            txd_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            txd_r  <= txd_next_s;
            done_r <= done_next_s;
            if (accept_s) begin
                shreg_r <= Data_in;
                baud_r  <= {BAUD_W{1'b0}};
                bit_r   <= {BIT_W{1'b0}};
            end else if (state_r != IDLE) begin
                if (bit_end_s) baud_r <= {BAUD_W{1'b0}};
                else           baud_r <= baud_r + BAUD_W'(1);
                if ((state_r == START) && bit_end_s) begin
                    bit_r <= {BIT_W{1'b0}};
                end else if ((state_r == DATA) && bit_end_s) begin
                    shreg_r <= shifted_s;
                    bit_r   <= bit_r + BIT_W'(1);
                end else begin
                    bit_r <= bit_r;
                end
            end else begin
                baud_r <= baud_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sreg.sv
// Directed bench for uart_tx_sreg with CLKS_PER_BIT=4: table of frames plus
// hand-written back-to-back, busy-load and mid-frame reset sequences.
module tb_uart_tx_sreg;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic       ready;
    logic       done;
    logic       txd;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[k] = TXD level during bit time k
    } vec_t;

    vec_t vecs[5];

    uart_tx_sreg #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .Load    (load),
        .Data_in (data_in),
        .Ready   (ready),
        .Done    (done),
        .TXD     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Sends one frame starting at a sample point with Ready=1 and checks every
    // cycle of it; a bench-side receiver samples each data bit at mid-bit.
    task automatic do_frame(input logic [7:0] d, input logic [9:0] fr,
                            input bit hold, input int poke_k);
        logic [7:0] rx;
        logic       eb;
        rx = 8'h00;
        chk("ready_before_load", 32'(ready), 32'd1);
        load    = 1'b1;
        data_in = d;
        tick();
        if (!hold) load = 1'b0;
        data_in = ~d;
        for (int k = 0; k < 10 * CPB; k++) begin
            eb = fr[4'(k / CPB)];
            chk($sformatf("txd_%02h_k%0d", d, k), 32'(txd), 32'(eb));
            chk($sformatf("ready_busy_%02h_k%0d", d, k), 32'(ready), 32'd0);
            chk($sformatf("done_busy_%02h_k%0d", d, k), 32'(done), 32'd0);
            if ((k % CPB == 2) && (k / CPB >= 1) && (k / CPB <= 8)) rx = {txd, rx[7:1]};
            if (k == poke_k) begin
                load    = 1'b1;
                data_in = 8'hFF;
            end else if (!hold) begin
                load = 1'b0;
            end
            tick();
        end
        chk($sformatf("rx_loopback_%02h", d), 32'(rx), 32'(d));
        chk($sformatf("ready_end_%02h", d), 32'(ready), 32'd1);
        chk($sformatf("done_end_%02h", d), 32'(done), 32'd1);
        chk($sformatf("txd_end_%02h", d), 32'(txd), 32'd1);
        done_cyc = cyc;
    endtask

    initial begin
        int c1;
        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'h01, 10'h202};
        vecs[2] = '{8'h80, 10'h300};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'h00, 10'h200};

        // Reset with Load held high: outputs idle before any clock edge.
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 8'hC3;
        #2;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        repeat (3) tick();
        chk("rst_load_txd", 32'(txd), 32'd1);
        chk("rst_load_ready", 32'(ready), 32'd1);
        load = 1'b0;
        rst  = 1'b0;
        tick();
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_ready", 32'(ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            do_frame(vecs[i].data, vecs[i].frame, 1'b0, -1);
            tick();
            chk($sformatf("done_pulse_once_%0d", i), 32'(done), 32'd0);
            chk($sformatf("idle_txd_%0d", i), 32'(txd), 32'd1);
        end

        // Back-to-back with Load held: one idle cycle, Done pulses 41 apart.
        do_frame(8'hA3, 10'h346, 1'b1, -1);
        c1 = done_cyc;
        do_frame(8'h3C, 10'h278, 1'b0, -1);
        chk("b2b_done_spacing", 32'(done_cyc - c1), 32'd41);
        tick();
        chk("b2b_done_low", 32'(done), 32'd0);

        // Load of 0xFF at cycle 10 of a 0x00 frame must be ignored.
        do_frame(8'h00, 10'h200, 1'b0, 10);
        for (int k = 0; k < 2 * CPB; k++) begin
            tick();
            chk($sformatf("busy_ff_not_sent_k%0d", k), 32'(txd), 32'd1);
            chk($sformatf("busy_ff_ready_k%0d", k), 32'(ready), 32'd1);
        end

        // Mid-frame reset during data bit 3 of 0xF0.
        load    = 1'b1;
        data_in = 8'hF0;
        tick();
        load = 1'b0;
        repeat (17) tick();
        chk("pre_abort_txd", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_txd_async", 32'(txd), 32'd1);
        chk("abort_ready_async", 32'(ready), 32'd1);
        chk("abort_done_async", 32'(done), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("abort_no_done_k%0d", k), 32'(done), 32'd0);
            chk($sformatf("abort_idle_txd_k%0d", k), 32'(txd), 32'd1);
        end
        do_frame(8'h5A, 10'h2B4, 1'b0, -1);
        tick();
        chk("final_done_low", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
